// File: rtl/btn_event_fsm_if.sv
// rtl/btn_event_fsm_if.sv - debounced-level input and gesture-event outputs of btn_event_fsm
//   db        : debounced switch level (master -> slave)
//   short_p   : one-cycle single-click pulse (slave -> master)
//   double_p  : one-cycle double-click pulse (slave -> master)
//   long_p    : one-cycle long-press pulse (slave -> master)
//   press_cnt : running count of classified events, wraps (slave -> master)
//   busy      : gesture in progress (slave -> master)
interface btn_event_fsm_if #(
    parameter int CNT_W = 8
);
    logic             db;
    logic             short_p;
    logic             double_p;
    logic             long_p;
    logic [CNT_W-1:0] press_cnt;
    logic             busy;

    modport master (
        output db,
        input  short_p, double_p, long_p, press_cnt, busy
    );

    modport slave (
        input  db,
        output short_p, double_p, long_p, press_cnt, busy
    );
endinterface

// File: rtl/btn_event_fsm.sv
// rtl/btn_event_fsm.sv - classifies debounced button gestures into short, double and long events
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : btn_event_fsm_if.slave (db in; short_p, double_p, long_p, press_cnt, busy out)
module btn_event_fsm #(
    parameter int TICK_N       = 20,
    parameter int LONG_TICKS   = 100,
    parameter int DCLICK_TICKS = 30,
    parameter int CNT_W        = 8
) (
    input  logic            clk,
    input  logic            reset,
    btn_event_fsm_if.slave  bus
);
    localparam int T_MAX = (LONG_TICKS > DCLICK_TICKS) ? LONG_TICKS : DCLICK_TICKS;
    localparam int TW    = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0]     T_LONG   = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0]     T_DCLICK = TW'(DCLICK_TICKS - 1);
    localparam logic [TW-1:0]     T_ONE    = TW'(1);
    localparam logic [TICK_N-1:0] Q_ONE    = TICK_N'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t            state;
    logic              db_reg;
    logic [TICK_N-1:0] q;
    logic [TW-1:0]     t;
    logic              short_r;
    logic              double_r;
    logic              long_r;
    logic [CNT_W-1:0]  cnt_r;

    logic rise;
    logic fall;
    logic tick;

    assign rise = bus.db & ~db_reg;
    assign fall = ~bus.db & db_reg;
    assign tick = (q == {TICK_N{1'b1}});

    // Tick phase is free-running and deliberately not realigned on state entry.
    // Every transition below clears t; a later nonblocking write overrides the
    // default tick increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            db_reg   <= 1'b0;
            q        <= '0;
            t        <= '0;
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
            cnt_r    <= '0;
        end else begin
            db_reg   <= bus.db;
            q        <= q + Q_ONE;
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
            if (tick) begin
                t <= t + T_ONE;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESS1;
                        t     <= '0;
                    end
                end
                PRESS1: begin
                    if (fall) begin
                        state <= WAIT2;
                        t     <= '0;
                    end else if (tick && t == T_LONG) begin
                        state  <= HOLD;
                        t      <= '0;
                        long_r <= 1'b1;
                        cnt_r  <= cnt_r + CNT_ONE;
                    end
                end
                WAIT2: begin
                    if (rise) begin
                        state <= PRESS2;
                        t     <= '0;
                    end else if (tick && t == T_DCLICK) begin
                        state   <= IDLE;
                        t       <= '0;
                        short_r <= 1'b1;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                PRESS2: begin
                    // A second press held past the long timeout becomes a long
                    // press instead of a double click.
                    if (fall) begin
                        state    <= IDLE;
                        t        <= '0;
                        double_r <= 1'b1;
                        cnt_r    <= cnt_r + CNT_ONE;
                    end else if (tick && t == T_LONG) begin
                        state  <= HOLD;
                        t      <= '0;
                        long_r <= 1'b1;
                        cnt_r  <= cnt_r + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (fall) begin
                        state <= IDLE;
                        t     <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    t     <= '0;
                end
            endcase
        end
    end

    assign bus.short_p   = short_r;
    assign bus.double_p  = double_r;
    assign bus.long_p    = long_r;
    assign bus.press_cnt = cnt_r;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_btn_event_fsm.sv
// tb/tb_btn_event_fsm.sv - self-checking bench for btn_event_fsm
module tb_btn_event_fsm;
    localparam int TICK_N = 2;
    localparam int LONG   = 5;
    localparam int DCLICK = 3;
    localparam int CNT_W  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    btn_event_fsm_if #(.CNT_W(CNT_W)) bus ();

    btn_event_fsm #(
        .TICK_N(TICK_N), .LONG_TICKS(LONG), .DCLICK_TICKS(DCLICK), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_s, n_d, n_l;
    int last_s_cyc, last_l_cyc, last_cnt;

    // Gesture-level reference: how many presses the current gesture has seen,
    // whether the button is down, whether it already became a long press, and
    // ticks elapsed since the last press/release.
    int m_q, m_presses, m_ticks, m_cnt;
    bit m_held, m_longed, m_prev;
    bit e_s, e_d, e_l;

    task automatic model_edge(input bit r, input bit d);
        bit tk, rs, fl;
        e_s = 0; e_d = 0; e_l = 0;
        if (r) begin
            m_q = 0; m_prev = 0; m_presses = 0; m_held = 0;
            m_longed = 0; m_ticks = 0; m_cnt = 0;
        end else begin
            tk = (m_q == (1 << TICK_N) - 1);
            m_q = (m_q + 1) % (1 << TICK_N);
            rs = d && !m_prev;
            fl = !d && m_prev;
            m_prev = d;
            if (m_presses == 0) begin
                if (rs) begin
                    m_presses = 1; m_held = 1; m_longed = 0; m_ticks = 0;
                end
            end else if (m_held) begin
                if (fl) begin
                    if (m_longed) m_presses = 0;
                    else if (m_presses == 2) begin e_d = 1; m_presses = 0; end
                    else begin m_held = 0; m_ticks = 0; end
                end else if (tk && !m_longed) begin
                    m_ticks++;
                    if (m_ticks == LONG) begin e_l = 1; m_longed = 1; end
                end
            end else begin
                if (rs) begin
                    m_presses = 2; m_held = 1; m_ticks = 0;
                end else if (tk) begin
                    m_ticks++;
                    if (m_ticks == DCLICK) begin e_s = 1; m_presses = 0; end
                end
            end
            if (e_s || e_d || e_l) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic step();
        logic [5:0] act, exp;
        @(posedge clk);
        model_edge(reset, bus.db);
        #1;
        cyc++;
        if (bus.short_p)  begin n_s++; last_s_cyc = cyc; last_cnt = int'(bus.press_cnt); end
        if (bus.double_p) n_d++;
        if (bus.long_p)   begin n_l++; last_l_cyc = cyc; end
        act = {bus.short_p, bus.double_p, bus.long_p, bus.busy, bus.press_cnt};
        exp = {e_s, e_d, e_l, (m_presses != 0), 2'(m_cnt)};
        check("model", int'(act), int'(exp));
    endtask

    task automatic steps(input bit d, input int n);
        bus.db = d;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.db = 1'b0;
        step();
        reset = 1'b0;
        n_s = 0; n_d = 0; n_l = 0;
        last_s_cyc = 0; last_l_cyc = 0; last_cnt = -1;
    endtask

    typedef struct {
        int h1; int gap; int h2;
        int n_s; int n_d; int n_l;
    } gest_t;

    gest_t tbl[$];
    int fall_cyc, rise_cyc, run_left;

    initial begin
        bus.db = 1'b0;
        tbl = '{
            '{8,  0,  0, 1, 0, 0},
            '{6,  4,  6, 0, 1, 0},
            '{40, 0,  0, 0, 0, 1},
            '{6,  4, 30, 0, 0, 1},
            '{6, 12,  6, 2, 0, 0},
            '{1,  0,  0, 1, 0, 0},
            '{3,  2,  3, 0, 1, 0},
            '{19, 0,  0, 1, 0, 0},
            '{20, 0,  0, 0, 0, 1},
            '{6,  9,  3, 0, 1, 0},
            '{6, 10,  3, 2, 0, 0}
        };

        // Reset state
        do_reset();
        check("rst_pulses", int'({bus.short_p, bus.double_p, bus.long_p}), 0);
        check("rst_cnt", int'(bus.press_cnt), 0);
        check("rst_busy", int'(bus.busy), 0);

        // Gesture table
        foreach (tbl[k]) begin
            do_reset();
            steps(1'b1, tbl[k].h1);
            steps(1'b0, tbl[k].gap);
            if (tbl[k].h2 > 0) steps(1'b1, tbl[k].h2);
            steps(1'b0, 40);
            check($sformatf("tbl%0d_short", k), n_s, tbl[k].n_s);
            check($sformatf("tbl%0d_double", k), n_d, tbl[k].n_d);
            check($sformatf("tbl%0d_long", k), n_l, tbl[k].n_l);
            check($sformatf("tbl%0d_cnt", k), int'(bus.press_cnt),
                  (tbl[k].n_s + tbl[k].n_d + tbl[k].n_l) % (1 << CNT_W));
            check($sformatf("tbl%0d_busy", k), int'(bus.busy), 0);
        end

        // Single-click latency from the fall
        do_reset();
        steps(1'b1, 8);
        bus.db = 1'b0;
        step();
        fall_cyc = cyc;
        steps(1'b0, 20);
        check("click_count", n_s, 1);
        check_rng("click_latency", last_s_cyc - fall_cyc, 9, 12);

        // Long-press latency from the rise, with a late tick phase
        do_reset();
        steps(1'b0, 2);
        bus.db = 1'b1;
        step();
        rise_cyc = cyc;
        steps(1'b1, 39);
        steps(1'b0, 20);
        check("long_count", n_l, 1);
        check_rng("long_latency", last_l_cyc - rise_cyc, 17, 20);
        check("long_no_other", n_s + n_d, 0);

        // Reset while waiting for a second press
        do_reset();
        steps(1'b1, 6);
        steps(1'b0, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_cnt", int'(bus.press_cnt), 0);
        steps(1'b0, 30);
        check("midrst_no_short", n_s, 0);

        // Counter wrap over five clicks
        do_reset();
        for (int i = 0; i < 5; i++) begin
            steps(1'b1, 4);
            steps(1'b0, 16);
            check($sformatf("wrap_cnt%0d", i), last_cnt, (i + 1) % 4);
        end
        check("wrap_shorts", n_s, 5);

        // Randomized level runs with occasional resets, checked against the model
        do_reset();
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                bus.db = ~bus.db;
                run_left = $urandom_range(1, 26);
            end
            run_left--;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
